tx_burst_shaper: RTL and testbench

Downstream stage of the single-tone DDS wrapper. Consumes the 32-bit DDS sample stream (cos in [15:0], sin in [31:16], signed 16-bit each) and gates it into shaped transmit bursts with linear amplitude ramp-up and ramp-down. The shaped stream feeds the DAC interface, which receives an unbroken sample stream: zeros between bursts.

---
 rtl/tx_pkg.sv | 15 +
 rtl/tx_gain_lane.sv | 32 +++
 rtl/tx_burst_shaper.sv | 153 +++++++++++++++
 tb/tb_tx_burst_shaper.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and lane layout for the transmit burst shaper.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } tx_state_e;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned COS_LSB  = 0;
  localparam int unsigned SIN_LSB  = 16;

endpackage

// File: rtl/tx_gain_lane.sv
// One signed sample lane scaled by an unsigned gain fraction, floor shift, registered.
module tx_gain_lane
  import tx_pkg::*;
#(
  parameter int unsigned GAIN_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [GAIN_W:0]     gain,
  output logic [SAMPLE_W-1:0] result
);

  localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 2;

  logic signed [PROD_W-1:0] prod;
  logic [SAMPLE_W-1:0]      result_d, result_q;

  always_comb begin
    prod     = $signed({{(GAIN_W + 2){sample[SAMPLE_W-1]}}, sample})
             * $signed({{(SAMPLE_W + 1){1'b0}}, gain});
    result_d = SAMPLE_W'(prod >>> GAIN_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: rtl/tx_burst_shaper.sv
// Gates the DDS sample stream into bursts with linear gain ramps; fixed 2-cycle latency.
module tx_burst_shaper
  import tx_pkg::*;
#(
  parameter int unsigned RAMP_LOG2 = 4,
  parameter int unsigned GAIN_W    = 12,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             GCLK,
  input  logic             reset,
  input  logic [31:0]      DDS_DATA,
  input  logic             DDS_DATA_VALID,
  input  logic             BURST_START,
  input  logic             BURST_ABORT,
  input  logic [LEN_W-1:0] BURST_LEN,
  output logic [31:0]      DAC_DATA,
  output logic             DAC_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned K_W    = RAMP_LOG2 + 1;
  localparam logic [K_W-1:0] K_MAX  = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_LAST = K_MAX - K_ONE;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  tx_state_e        state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [K_W-1:0]   kg;
  logic [GAIN_W:0]  gain;

  logic [31:0]      s1_data_q, s1_data_d;
  logic             s1_valid_q, s1_valid_d;
  logic [GAIN_W:0]  s1_gain_q, s1_gain_d;
  logic             dac_valid_q, dac_valid_d;

  // Ramp-down applies k-1, so an abort continues from the last applied gain.
  always_comb begin
    kg = '0;
    unique case (state_q)
      RAMP_UP, HOLD: kg = k_q;
      RAMP_DOWN:     kg = k_q - K_ONE;
      default:       kg = '0;
    endcase
    gain = (GAIN_W + 1)'(kg) << (GAIN_W - RAMP_LOG2);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (BURST_START) begin
          state_d = RAMP_UP;
          k_d     = '0;
          len_d   = BURST_LEN;
          cnt_d   = '0;
        end
      end
      RAMP_UP: begin
        if (BURST_ABORT) begin
          if (k_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP_DOWN;
          end
        end else if (DDS_DATA_VALID) begin
          k_d = k_q + K_ONE;
          if (k_q == K_LAST) state_d = (len_q == '0) ? RAMP_DOWN : HOLD;
        end
      end
      HOLD: begin
        if (BURST_ABORT) begin
          state_d = RAMP_DOWN;
        end else if (DDS_DATA_VALID) begin
          if (cnt_q == len_q - LEN_ONE) state_d = RAMP_DOWN;
          else                          cnt_d   = cnt_q + LEN_ONE;
        end
      end
      RAMP_DOWN: begin
        if (DDS_DATA_VALID) begin
          k_d = k_q - K_ONE;
          if (k_q == K_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_data_d   = DDS_DATA;
    s1_valid_d  = DDS_DATA_VALID;
    s1_gain_d   = gain;
    dac_valid_d = s1_valid_q;
  end

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_gain_q   <= '0;
      dac_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      s1_gain_q   <= s1_gain_d;
      dac_valid_q <= dac_valid_d;
    end
  end

  tx_gain_lane #(.GAIN_W(GAIN_W)) u_cos (
    .clk    (GCLK),
    .rst_n  (reset),
    .sample (s1_data_q[COS_LSB +: SAMPLE_W]),
    .gain   (s1_gain_q),
    .result (DAC_DATA[COS_LSB +: SAMPLE_W])
  );

  tx_gain_lane #(.GAIN_W(GAIN_W)) u_sin (
    .clk    (GCLK),
    .rst_n  (reset),
    .sample (s1_data_q[SIN_LSB +: SAMPLE_W]),
    .gain   (s1_gain_q),
    .result (DAC_DATA[SIN_LSB +: SAMPLE_W])
  );

  assign DAC_VALID = dac_valid_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;

endmodule

// File: tb/tb_tx_burst_shaper.sv
// Directed bench for tx_burst_shaper with RAMP_LOG2=2, GAIN_W=8.
module tb_tx_burst_shaper;

  logic        GCLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dds_data = '0;
  logic        dds_valid = 1'b0;
  logic        burst_start = 1'b0;
  logic        burst_abort = 1'b0;
  logic [15:0] burst_len = '0;
  logic [31:0] DAC_DATA;
  logic        DAC_VALID, BUSY, DONE;

  int checks = 0;
  int failures = 0;

  logic [31:0] got[$];
  int          done_cnt = 0;
  int          busy_cnt = 0;

  localparam logic [31:0] D4 = 32'h4000_4000;

  tx_burst_shaper #(.RAMP_LOG2(2), .GAIN_W(8), .LEN_W(16)) dut (
    .GCLK           (GCLK),
    .reset          (reset),
    .DDS_DATA       (dds_data),
    .DDS_DATA_VALID (dds_valid),
    .BURST_START    (burst_start),
    .BURST_ABORT    (burst_abort),
    .BURST_LEN      (burst_len),
    .DAC_DATA       (DAC_DATA),
    .DAC_VALID      (DAC_VALID),
    .BUSY           (BUSY),
    .DONE           (DONE)
  );

  always #5 GCLK = ~GCLK;

  always @(negedge GCLK) begin
    if (DAC_VALID) got.push_back(DAC_DATA);
    if (DONE) done_cnt++;
    if (BUSY && dds_valid) busy_cnt++;
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic a);
    dds_valid = v; dds_data = d; burst_start = s; burst_abort = a;
    @(posedge GCLK); #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    got.delete(); done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic test_reset();
    dds_valid = 1'b1; burst_start = 1'b1; dds_data = D4;
    repeat (3) @(posedge GCLK);
    #1;
    checks++; if (DAC_DATA !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", DAC_DATA); end
    checks++; if (DAC_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", DAC_VALID); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
    dds_valid = 1'b0; burst_start = 1'b0;
    reset = 1'b1;
    @(posedge GCLK); #1;
    clear();
  endtask

  task automatic test_basic_burst();
    logic [31:0] e [11] = '{32'h0000_0000, 32'h1000_1000, 32'h2000_2000, 32'h3000_3000,
                            32'h4000_4000, 32'h4000_4000, 32'h4000_4000, 32'h3000_3000,
                            32'h2000_2000, 32'h1000_1000, 32'h0000_0000};
    clear();
    burst_len = 16'd3;
    drive(1'b0, D4, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b1, D4, 1'b0, 1'b0);
    flush();
    checks++; if (got.size() != 11) begin failures++; $display("FAIL basic_count got=%0d exp=11", got.size()); end
    for (int i = 0; i < 11; i++) if (i < got.size()) begin
      checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL basic_s%0d got=%h exp=%h", i, got[i], e[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    checks++; if (busy_cnt != 11) begin failures++; $display("FAIL basic_busy got=%0d exp=11", busy_cnt); end
  endtask

  task automatic test_negative();
    logic [31:0] e [9] = '{32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_D000,
                           32'hFFFF_C000, 32'hFFFF_D000, 32'hFFFF_E000, 32'hFFFF_F000,
                           32'h0000_0000};
    clear();
    burst_len = 16'd1;
    drive(1'b0, 32'hFFFF_C000, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 32'hFFFF_C000, 1'b0, 1'b0);
    flush();
    checks++; if (got.size() != 9) begin failures++; $display("FAIL neg_count got=%0d exp=9", got.size()); end
    for (int i = 0; i < 9; i++) if (i < got.size()) begin
      checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL neg_s%0d got=%h exp=%h", i, got[i], e[i]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] e [9] = '{32'h0000_0000, 32'h1000_1000, 32'h2000_2000, 32'h3000_3000,
                           32'h4000_4000, 32'h3000_3000, 32'h2000_2000, 32'h1000_1000,
                           32'h0000_0000};
    clear();
    burst_len = 16'd10;
    drive(1'b0, D4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, D4, 1'b0, 1'b0);
    drive(1'b0, D4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, D4, 1'b0, 1'b0);
    flush();
    checks++; if (got.size() != 9) begin failures++; $display("FAIL abort_count got=%0d exp=9", got.size()); end
    for (int i = 0; i < 9; i++) if (i < got.size()) begin
      checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL abort_s%0d got=%h exp=%h", i, got[i], e[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL abort_done got=%0d exp=1", done_cnt); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_valid_gaps();
    logic        vh [16];
    logic [31:0] e [8] = '{32'h0000_0000, 32'h1000_1000, 32'h2000_2000, 32'h3000_3000,
                           32'h3000_3000, 32'h2000_2000, 32'h1000_1000, 32'h0000_0000};
    clear();
    burst_len = 16'd0;
    drive(1'b0, D4, 1'b1, 1'b0);
    burst_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vh[i] = (i % 2 == 0);
      dds_valid = vh[i];
      @(negedge GCLK);
      if (i >= 2) begin
        checks++;
        if (DAC_VALID !== vh[i-2]) begin failures++; $display("FAIL gap_valid_c%0d got=%b exp=%b", i, DAC_VALID, vh[i-2]); end
      end
      @(posedge GCLK); #1;
    end
    flush();
    checks++; if (got.size() != 8) begin failures++; $display("FAIL gap_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) if (i < got.size()) begin
      checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL gap_s%0d got=%h exp=%h", i, got[i], e[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL gap_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_start_in_hold();
    logic [31:0] e [14] = '{32'h0000_0000, 32'h1000_1000, 32'h2000_2000, 32'h3000_3000,
                            32'h4000_4000, 32'h4000_4000, 32'h4000_4000, 32'h3000_3000,
                            32'h2000_2000, 32'h1000_1000, 32'h0000_0000, 32'h0000_0000,
                            32'h0000_0000, 32'h0000_0000};
    clear();
    burst_len = 16'd3;
    drive(1'b0, D4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, D4, 1'b0, 1'b0);
    drive(1'b1, D4, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, D4, 1'b0, 1'b0);
    flush();
    checks++; if (got.size() != 14) begin failures++; $display("FAIL hold_start_count got=%0d exp=14", got.size()); end
    for (int i = 0; i < 14; i++) if (i < got.size()) begin
      checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL hold_start_s%0d got=%h exp=%h", i, got[i], e[i]); end
    end
    checks++; if (busy_cnt != 11) begin failures++; $display("FAIL hold_start_busy got=%0d exp=11", busy_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL hold_start_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_start_abort_idle();
    logic [31:0] e [11] = '{32'h0000_0000, 32'h1000_1000, 32'h2000_2000, 32'h3000_3000,
                            32'h4000_4000, 32'h4000_4000, 32'h4000_4000, 32'h3000_3000,
                            32'h2000_2000, 32'h1000_1000, 32'h0000_0000};
    clear();
    burst_len = 16'd3;
    drive(1'b0, D4, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) drive(1'b1, D4, 1'b0, 1'b0);
    flush();
    checks++; if (got.size() != 11) begin failures++; $display("FAIL sa_count got=%0d exp=11", got.size()); end
    for (int i = 0; i < 11; i++) if (i < got.size()) begin
      checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL sa_s%0d got=%h exp=%h", i, got[i], e[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL sa_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] e [11] = '{32'h0000_0000, 32'h1000_1000, 32'h2000_2000, 32'h3000_3000,
                            32'h4000_4000, 32'h4000_4000, 32'h4000_4000, 32'h3000_3000,
                            32'h2000_2000, 32'h1000_1000, 32'h0000_0000};
    clear();
    burst_len = 16'd3;
    drive(1'b0, D4, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, D4, 1'b0, 1'b0);
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", BUSY); end
    #2 reset = 1'b0;
    #1;
    checks++; if (DAC_DATA !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", DAC_DATA); end
    checks++; if (DAC_VALID !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", DAC_VALID); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", BUSY); end
    @(posedge GCLK); #1;
    @(posedge GCLK); #1;
    reset = 1'b1;
    drive(1'b0, D4, 1'b0, 1'b0);
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rst_mid_done got=%0d exp=0", done_cnt); end
    clear();
    drive(1'b0, D4, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b1, D4, 1'b0, 1'b0);
    flush();
    checks++; if (got.size() != 11) begin failures++; $display("FAIL rst_after_count got=%0d exp=11", got.size()); end
    for (int i = 0; i < 11; i++) if (i < got.size()) begin
      checks++; if (got[i] !== e[i]) begin failures++; $display("FAIL rst_after_s%0d got=%h exp=%h", i, got[i], e[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rst_after_done got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_negative();
    test_abort();
    test_valid_gaps();
    test_start_in_hold();
    test_start_abort_idle();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
